// File: rtl/hls_ctrl_initiator_if.sv
// rtl/hls_ctrl_initiator_if.sv - command, kernel ap_ctrl and result signals of the HLS initiator
interface hls_ctrl_initiator_if #(
    parameter int RET_W = 32,
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_count;
    logic             k_start;
    logic             k_ready;
    logic             k_done;
    logic             k_idle;
    logic [RET_W-1:0] k_return;
    logic             res_valid;
    logic             res_ready;
    logic [RET_W-1:0] res_data;
    logic             res_last;

    modport master (
        input  cmd_valid, cmd_count, k_ready, k_done, k_idle, k_return, res_ready,
        output cmd_ready, k_start, res_valid, res_data, res_last
    );

    modport slave (
        output cmd_valid, cmd_count, k_ready, k_done, k_idle, k_return, res_ready,
        input  cmd_ready, k_start, res_valid, res_data, res_last
    );
endinterface

// File: rtl/hls_ctrl_initiator.sv
// rtl/hls_ctrl_initiator.sv - drives an HLS ap_ctrl_hs kernel N times per command and streams its ap_return values
module hls_ctrl_initiator #(
    parameter int RET_W   = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    hls_ctrl_initiator_if.master bus,
    output logic                 busy,
    output logic                 err_timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    // Abort on the cycle whose increment would make the counter reach TIMEOUT-1.
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 2);

    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;
    logic [TW-1:0]    tcnt_q;
    logic [TW-1:0]    tcnt_d;
    logic             cmd_ready_q;
    logic             k_start_q;
    logic             res_valid_q;
    logic             res_last_q;
    logic [RET_W-1:0] res_data_q;
    logic             busy_q;
    logic             err_q;
    logic             unused_k_idle;

    assign remaining_d   = remaining_q - 1'b1;
    assign tcnt_d        = tcnt_q + 1'b1;
    assign unused_k_idle = bus.k_idle;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            tcnt_q      <= '0;
            cmd_ready_q <= 1'b1;
            k_start_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        err_q <= 1'b0;
                        if (bus.cmd_count != '0) begin
                            remaining_q <= bus.cmd_count;
                            tcnt_q      <= '0;
                            k_start_q   <= 1'b1;
                            busy_q      <= 1'b1;
                            cmd_ready_q <= 1'b0;
                            state_q     <= START;
                        end
                    end
                end
                START, WAIT: begin
                    // In START a done only counts once the kernel has also taken the start.
                    if (bus.k_done && (state_q == WAIT || bus.k_ready)) begin
                        res_data_q  <= bus.k_return;
                        remaining_q <= remaining_d;
                        res_last_q  <= (remaining_d == '0);
                        res_valid_q <= 1'b1;
                        k_start_q   <= 1'b0;
                        state_q     <= OUT;
                    end else if (tcnt_q == TLAST) begin
                        err_q       <= 1'b1;
                        k_start_q   <= 1'b0;
                        remaining_q <= '0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_d;
                        if (state_q == START && bus.k_ready) begin
                            k_start_q <= 1'b0;
                            state_q   <= WAIT;
                        end
                    end
                end
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        res_last_q  <= 1'b0;
                        if (remaining_q == '0) begin
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            tcnt_q    <= '0;
                            k_start_q <= 1'b1;
                            state_q   <= START;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.k_start   = k_start_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_last  = res_last_q;
    assign bus.res_data  = res_data_q;
    assign busy          = busy_q;
    assign err_timeout   = err_q;
endmodule

// File: tb/tb_hls_ctrl_initiator.sv
// tb/tb_hls_ctrl_initiator.sv - directed self-checking bench for hls_ctrl_initiator
module tb_hls_ctrl_initiator;
    logic ap_clk;
    logic ap_rst_n;
    logic busy;
    logic err_timeout;
    int   checks;
    int   errors;

    hls_ctrl_initiator_if #(.RET_W(32), .CNT_W(16)) bus ();

    hls_ctrl_initiator #(.RET_W(32), .CNT_W(16), .TIMEOUT(16)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .bus         (bus.master),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] cnt);
        bus.cmd_valid = 1'b1;
        bus.cmd_count = cnt;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_count = '0;
    endtask

    task automatic wait_kstart(input string tag);
        int n;
        n = 0;
        while (bus.k_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus.k_start}, 32'd1);
    endtask

    // Kernel accepts on the first start cycle, then finishes two WAIT cycles later.
    task automatic kernel_run(input logic [31:0] ret);
        bus.k_ready = 1'b1;
        tick();
        bus.k_ready = 1'b0;
        tick();
        tick();
        bus.k_done   = 1'b1;
        bus.k_return = ret;
        tick();
        bus.k_done   = 1'b0;
        bus.k_return = '0;
    endtask

    initial begin
        int n;
        logic seen_valid;
        checks        = 0;
        errors        = 0;
        ap_rst_n      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_count = '0;
        bus.k_ready   = 1'b0;
        bus.k_done    = 1'b0;
        bus.k_idle    = 1'b1;
        bus.k_return  = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();

        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_k_start",   {31'd0, bus.k_start},   32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_data",  bus.res_data,           32'd0);
        check("rst_busy",      {31'd0, busy},          32'd0);
        check("rst_err",       {31'd0, err_timeout},   32'd0);

        // Single invocation returning 0xA5
        send_cmd(16'd1);
        check("t1_k_start",   {31'd0, bus.k_start},   32'd1);
        check("t1_busy",      {31'd0, busy},          32'd1);
        check("t1_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        bus.k_ready = 1'b1;
        tick();
        bus.k_ready = 1'b0;
        check("t1_k_start_low", {31'd0, bus.k_start}, 32'd0);
        tick();
        tick();
        bus.k_done   = 1'b1;
        bus.k_return = 32'h0000_00A5;
        tick();
        bus.k_done   = 1'b0;
        bus.k_return = '0;
        check("t1_res_valid", {31'd0, bus.res_valid}, 32'd1);
        check("t1_res_data",  bus.res_data,           32'h0000_00A5);
        check("t1_res_last",  {31'd0, bus.res_last},  32'd1);
        tick();
        check("t1_res_hold", bus.res_data, 32'h0000_00A5);
        check("t1_busy_hold", {31'd0, busy}, 32'd1);
        bus.res_ready = 1'b1;
        tick();
        check("t1_res_valid_end", {31'd0, bus.res_valid}, 32'd0);
        check("t1_busy_end",      {31'd0, busy},          32'd0);
        check("t1_cmd_ready_end", {31'd0, bus.cmd_ready}, 32'd1);

        // Three invocations, second result back-pressured for 4 cycles
        send_cmd(16'd3);
        for (int i = 1; i <= 3; i++) begin
            wait_kstart($sformatf("t2_start%0d", i));
            bus.res_ready = (i != 2);
            kernel_run(32'(i));
            check($sformatf("t2_valid%0d", i), {31'd0, bus.res_valid}, 32'd1);
            check($sformatf("t2_data%0d", i),  bus.res_data,           32'(i));
            check($sformatf("t2_last%0d", i),  {31'd0, bus.res_last},  {31'd0, i == 3});
            if (i == 2) begin
                for (int j = 0; j < 4; j++) begin
                    tick();
                    check("t2_stall_valid",   {31'd0, bus.res_valid}, 32'd1);
                    check("t2_stall_data",    bus.res_data,           32'd2);
                    check("t2_stall_k_start", {31'd0, bus.k_start},   32'd0);
                end
                bus.res_ready = 1'b1;
            end
            tick();
        end
        check("t2_busy_end", {31'd0, busy}, 32'd0);
        check("t2_valid_end", {31'd0, bus.res_valid}, 32'd0);

        // Ready and done together on the first start cycle
        send_cmd(16'd1);
        check("t3_k_start", {31'd0, bus.k_start}, 32'd1);
        bus.k_ready  = 1'b1;
        bus.k_done   = 1'b1;
        bus.k_return = 32'h0000_0077;
        tick();
        bus.k_ready  = 1'b0;
        bus.k_done   = 1'b0;
        bus.k_return = '0;
        check("t3_k_start_low", {31'd0, bus.k_start},   32'd0);
        check("t3_res_valid",   {31'd0, bus.res_valid}, 32'd1);
        check("t3_res_data",    bus.res_data,           32'h0000_0077);
        check("t3_res_last",    {31'd0, bus.res_last},  32'd1);
        tick();
        check("t3_busy_end", {31'd0, busy}, 32'd0);

        // Kernel never finishes: timeout after 15 START/WAIT cycles
        send_cmd(16'd2);
        bus.k_ready = 1'b1;
        n = 0;
        seen_valid = 1'b0;
        while (err_timeout !== 1'b1 && n < 40) begin
            tick();
            bus.k_ready = 1'b0;
            n++;
            if (bus.res_valid === 1'b1) seen_valid = 1'b1;
        end
        check("t4_err",         {31'd0, err_timeout},   32'd1);
        check("t4_cycles",      32'(n),                 32'd15);
        check("t4_no_result",   {31'd0, seen_valid},    32'd0);
        check("t4_k_start",     {31'd0, bus.k_start},   32'd0);
        check("t4_busy",        {31'd0, busy},          32'd0);
        check("t4_cmd_ready",   {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        check("t4_err_sticky",  {31'd0, err_timeout},   32'd1);

        // Zero-count command: accepted at once, clears the error, no activity
        send_cmd(16'd0);
        check("t5_err_clear",  {31'd0, err_timeout},   32'd0);
        check("t5_cmd_ready",  {31'd0, bus.cmd_ready}, 32'd1);
        check("t5_busy",       {31'd0, busy},          32'd0);
        seen_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (bus.k_start === 1'b1 || bus.res_valid === 1'b1) seen_valid = 1'b1;
            tick();
        end
        check("t5_no_activity", {31'd0, seen_valid}, 32'd0);

        // Reset pulsed during WAIT, then a stray done
        send_cmd(16'd2);
        bus.k_ready = 1'b1;
        tick();
        bus.k_ready = 1'b0;
        tick();
        check("t6_in_wait", {31'd0, busy}, 32'd1);
        ap_rst_n = 1'b0;
        #1;
        check("t6_rst_busy",      {31'd0, busy},          32'd0);
        check("t6_rst_k_start",   {31'd0, bus.k_start},   32'd0);
        check("t6_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("t6_rst_res_data",  bus.res_data,           32'd0);
        tick();
        ap_rst_n = 1'b1;
        tick();
        bus.k_done   = 1'b1;
        bus.k_return = 32'h0000_DEAD;
        tick();
        bus.k_done   = 1'b0;
        bus.k_return = '0;
        tick();
        check("t6_stray_valid", {31'd0, bus.res_valid}, 32'd0);
        check("t6_stray_data",  bus.res_data,           32'd0);
        check("t6_stray_busy",  {31'd0, busy},          32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hls_ctrl_initiator.md
HLS_CTRL_INITIATOR -- requirements
Module: hls_ctrl_initiator

Interface
REQ-001 SHALL provide parameter RET_W, default 32, kernel ap_return width.
REQ-002 SHALL provide parameter CNT_W, default 16, invocation-count width.
REQ-003 SHALL provide parameter TIMEOUT, default 1024, max cycles per invocation from k_start rise to k_done.
REQ-004 SHALL have one clock and an asynchronous active-low reset: ap_clk, 1-bit input, rising-edge clock; ap_rst_n, 1-bit input, async active-low reset.
REQ-005 ports: cmd_valid  in  1  command request.
REQ-006 ports: cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 ports: cmd_count  in  CNT_W  number of kernel invocations requested.
REQ-008 ports: k_start  out  1  ap_start to kernel.
REQ-009 ports: k_ready  in  1  kernel ap_ready.
REQ-010 ports: k_done  in  1  kernel ap_done, single-cycle pulse.
REQ-011 ports: k_idle  in  1  kernel ap_idle, status only.
REQ-012 ports: k_return  in  RET_W  kernel ap_return, valid when k_done high.
REQ-013 ports: res_valid / res_ready  out / in  1  result handshake.
REQ-014 ports: res_data  out  RET_W  captured ap_return.
REQ-015 ports: res_last  out  1  marks final result of a command.
REQ-016 ports: busy  out  1  high in any state except IDLE.
REQ-017 ports: err_timeout  out  1  sticky timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, START, WAIT, OUT.
REQ-019 IDLE: cmd_ready=1; on cmd_valid with cmd_count>0 load remaining=cmd_count, clear err_timeout, go START.
REQ-020 cmd_valid with cmd_count=0 SHALL be accepted (clears err_timeout), produce no invocation and no result, stay IDLE.
REQ-021 START: k_start=1, held until k_ready sampled high; then k_start=0 next cycle and go WAIT, unless k_done sampled in same cycle (go OUT directly).
REQ-022 WAIT: k_start=0; on k_done capture k_return into res_data, decrement remaining, go OUT.
REQ-023 k_done in START coincident with k_ready SHALL be captured identically to REQ-022.
REQ-024 k_done outside START/WAIT SHALL be ignored.
REQ-025 OUT: res_valid=1, res_data and res_last stable until res_ready; res_last=1 iff remaining==0.
REQ-026 On res_valid&res_ready: remaining>0 -> START next cycle; remaining==0 -> IDLE.
REQ-027 Timeout counter SHALL clear on entry to START and increment every cycle in START/WAIT; reaching TIMEOUT-1 without k_done SHALL set err_timeout, drop k_start, discard remaining, go IDLE, emit no result.
REQ-028 Start-to-start latency SHALL be kernel latency + 2 cycles minimum with res_ready tied high.
REQ-029 cmd_ready SHALL be 0 outside IDLE; commands are never queued.
REQ-030 k_idle SHALL NOT affect FSM transitions.

Reset
REQ-031 ap_rst_n low SHALL immediately force IDLE, k_start=0, res_valid=0, res_last=0, res_data=0, busy=0, err_timeout=0, remaining=0, timeout counter=0; cmd_ready=1 after reset.
REQ-032 Reset asserted mid-invocation SHALL abort without emitting a result; a later k_done SHALL be ignored.

Verification
REQ-033 cmd_count=1, kernel ready 1 cycle after start, done 3 cycles later with k_return=0x0000_00A5 -> one result 0xA5, res_last=1, busy falls after handshake.
REQ-034 cmd_count=3, returns 1,2,3, res_ready low 4 cycles on second result -> res_data=2 held stable, k_start stays low, results 1,2,3 with res_last only on 3.
REQ-035 k_ready and k_done high in same cycle as first k_start -> result captured, k_start high exactly 1 cycle.
REQ-036 TIMEOUT=16, kernel never asserts k_done -> err_timeout=1 after 15 cycles in START/WAIT, k_start=0, IDLE, no res_valid; next cmd clears err_timeout.
REQ-037 cmd_count=0 -> accepted in 1 cycle, no k_start, no res_valid.
REQ-038 ap_rst_n pulsed low during WAIT -> all outputs reset immediately; subsequent stray k_done produces no result.
